// File: rtl/csa_pkg.sv
// Shared types and default widths for the carry-save accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csa_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int ACC_W_DEF = 12;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/csa_row.sv
// One row of full adders: compresses three W-bit words into a sum word and an unshifted carry word.
// Latency: purely combinational.
// Backpressure: none.
module csa_row #(
    parameter int W = 12
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    // Bitwise full-adder: parity gives the sum, majority gives the carry
    always_comb begin
        sum   = x ^ y ^ z;
        carry = (x & y) | (x & z) | (y & z);
    end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Sums a job of unsigned operands in carry-save form, then resolves with one carry-propagate add.
// Latency: last beat accepted on edge T -> out_valid high after edge T+2.
// Backpressure: in_ready low outside IDLE/ACCUM; result held in DONE until out_ready.
module csa_accum_ctrl
    import csa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    state_t             state_q;
    logic [ACC_W-1:0]   s_q;
    logic [ACC_W-1:0]   c_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic               out_ovf_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_valid_q;
    // Set once the carry-propagate result is registered; the next RESOLVE edge raises out_valid
    logic               sum_rdy_q;

    logic [ACC_W-1:0]   operand;
    logic [ACC_W-1:0]   row_sum;
    logic [ACC_W-1:0]   row_carry;
    logic [ACC_W:0]     final_sum;
    logic               accept;

    // Ready only while collecting operands, never during reset or a cancel
    always_comb begin
        in_ready = !rst && !abort && ((state_q == IDLE) || (state_q == ACCUM));
        accept   = in_valid && in_ready;
        operand  = {{(ACC_W-WIDTH){1'b0}}, in_data};
        // Extra top bit catches the carry out of the final resolve
        final_sum = {1'b0, s_q} + {1'b0, c_q};
    end

    csa_row #(
        .W (ACC_W)
    ) u_row (
        .x     (s_q),
        .y     (c_q),
        .z     (operand),
        .sum   (row_sum),
        .carry (row_carry)
    );

    // Job sequencing, carry-save state and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            sum_rdy_q   <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            sum_rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        s_q <= row_sum;
                        c_q <= row_carry << 1;
                        // A carry leaving the top bit means the true sum already exceeds the range
                        if (row_carry[ACC_W-1]) begin
                            out_ovf_q <= 1'b1;
                        end
                        if (out_count_q != {CNT_W{1'b1}}) begin
                            out_count_q <= out_count_q + 1'b1;
                        end
                        state_q <= in_last ? RESOLVE : ACCUM;
                    end
                end
                RESOLVE: begin
                    if (!sum_rdy_q) begin
                        out_sum_q <= final_sum[ACC_W-1:0];
                        if (final_sum[ACC_W]) begin
                            out_ovf_q <= 1'b1;
                        end
                        sum_rdy_q <= 1'b1;
                    end else begin
                        sum_rdy_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        s_q         <= '0;
                        c_q         <= '0;
                        out_ovf_q   <= 1'b0;
                        out_count_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomized bench for csa_accum_ctrl against an arithmetic job model.
// Latency: checks out_valid two edges after the last accepted beat.
// Backpressure: exercises held results, abort and reset mid-job.
module tb_csa_accum_ctrl;

    localparam int ACC = 12;
    localparam int CNT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_data;
    logic           in_last;
    logic           abort;
    logic           out_valid;
    logic           out_ready;
    logic [ACC-1:0] out_sum;
    logic           out_ovf;
    logic [CNT-1:0] out_count;

    logic           n_in_valid;
    logic           n_in_ready;
    logic [3:0]     n_in_data;
    logic           n_in_last;
    logic           n_abort;
    logic           n_out_valid;
    logic           n_out_ready;
    logic [5:0]     n_out_sum;
    logic           n_out_ovf;
    logic [7:0]     n_out_count;

    csa_accum_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    csa_accum_ctrl #(
        .WIDTH (4),
        .ACC_W (6),
        .CNT_W (8)
    ) dut_n (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_data   (n_in_data),
        .in_last   (n_in_last),
        .abort     (n_abort),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_sum   (n_out_sum),
        .out_ovf   (n_out_ovf),
        .out_count (n_out_count)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int job_q[$];

    // Reference: the job's true arithmetic sum, reduced to the result fields
    function automatic void model_job(output int es, output bit eo, output int ec);
        int total;
        total = 0;
        foreach (job_q[i]) total += job_q[i];
        es = total % (1 << ACC);
        eo = (total >= (1 << ACC));
        ec = (job_q.size() > 255) ? 255 : job_q.size();
    endfunction

    // Feeds job_q as beats; starts at a negedge, returns #1 after the edge accepting the final beat
    task automatic drive_job(input bit gaps, input bit last_on_end, output bit ok);
        int  idx;
        int  guard;
        bit  acc;
        idx   = 0;
        guard = 0;
        ok    = 1'b1;
        while (idx < job_q.size() && guard < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = in_valid ? 4'(job_q[idx]) : 4'($urandom);
            in_last  = last_on_end && (idx == job_q.size() - 1);
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            guard++;
            if (idx < job_q.size()) @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (idx < job_q.size()) ok = 1'b0;
    endtask

    // Counts negedges after the final accept until out_valid, bounded at 20
    task automatic wait_result(output int lat, output logic [ACC-1:0] s, output logic o,
                               output logic [CNT-1:0] c);
        lat = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = out_sum;
        o = out_ovf;
        c = out_count;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; abort = 1'b0; out_ready = 1'b1;
        n_in_valid = 1'b0; n_in_data = '0; n_in_last = 1'b0; n_abort = 1'b0; n_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++;
        if (out_sum !== '0) $display("FAIL reset_out_sum got %0d exp 0", out_sum); else pass_cnt++;
        chk_cnt++;
        if (out_count !== '0) $display("FAIL reset_out_count got %0d exp 0", out_count); else pass_cnt++;
        chk_cnt++;
        if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf got %b exp 0", out_ovf); else pass_cnt++;
        chk_cnt++;
        if ({n_out_valid, n_out_ovf, n_out_sum, n_out_count} !== '0)
            $display("FAIL reset_narrow_outputs got %h exp 0", {n_out_valid, n_out_ovf, n_out_sum, n_out_count});
        else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single operand straight after reset release; the first edge must accept it
    task automatic test_single();
        bit ok; int lat; logic [ACC-1:0] s; logic o; logic [CNT-1:0] c;
        job_q = '{9};
        drive_job(1'b0, 1'b1, ok);
        wait_result(lat, s, o, c);
        chk_cnt++;
        if (ok !== 1'b1) $display("FAIL single_accept got timeout exp accepted"); else pass_cnt++;
        chk_cnt++;
        if (lat != 2) $display("FAIL single_latency got %0d exp 2", lat); else pass_cnt++;
        chk_cnt++;
        if (s !== 12'd9) $display("FAIL single_sum got %0d exp 9", s); else pass_cnt++;
        chk_cnt++;
        if (c !== 8'd1) $display("FAIL single_count got %0d exp 1", c); else pass_cnt++;
        chk_cnt++;
        if (o !== 1'b0) $display("FAIL single_ovf got %b exp 0", o); else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (out_valid !== 1'b0 || out_count !== '0)
            $display("FAIL single_release got valid=%b count=%0d exp 0/0", out_valid, out_count);
        else pass_cnt++;
    endtask

    task automatic test_multi();
        bit ok; int lat; logic [ACC-1:0] s; logic o; logic [CNT-1:0] c;
        job_q = '{3, 5, 15, 7};
        drive_job(1'b1, 1'b1, ok);
        wait_result(lat, s, o, c);
        chk_cnt++;
        if (ok !== 1'b1 || lat != 2) $display("FAIL multi_latency got ok=%b lat=%0d exp 1/2", ok, lat); else pass_cnt++;
        chk_cnt++;
        if (s !== 12'd30) $display("FAIL multi_sum got %0d exp 30", s); else pass_cnt++;
        chk_cnt++;
        if (c !== 8'd4 || o !== 1'b0) $display("FAIL multi_count_ovf got %0d/%b exp 4/0", c, o); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [ACC-1:0] s; logic o; logic [CNT-1:0] c;
        int es; bit eo; int ec; int bad;
        job_q = '{};
        repeat (3) job_q.push_back(int'($urandom_range(0, 15)));
        model_job(es, eo, ec);
        out_ready = 1'b0;
        drive_job(1'b0, 1'b1, ok);
        wait_result(lat, s, o, c);
        chk_cnt++;
        if (lat != 2 || s !== ACC'(es)) $display("FAIL bp_result got lat=%0d sum=%0d exp 2/%0d", lat, s, es); else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            in_last  = 1'($urandom);
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== s || out_ovf !== o || out_count !== c)
                bad++;
            @(negedge clk);
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); else pass_cnt++;
        chk_cnt++;
        if (out_count !== CNT'(ec)) $display("FAIL bp_count got %0d exp %0d", out_count, ec); else pass_cnt++;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        @(negedge clk);
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0)
            $display("FAIL bp_to_idle got valid=%b ready=%b count=%0d exp 0/1/0", out_valid, in_ready, out_count);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        bit ok; int lat; logic [ACC-1:0] s; logic o; logic [CNT-1:0] c; int seen;
        job_q = '{4, 4};
        drive_job(1'b0, 1'b0, ok);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'd4; in_last = 1'b0; abort = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL abort_in_ready got %b exp 0", in_ready); else pass_cnt++;
        @(posedge clk);
        #1;
        abort = 1'b0; in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk_cnt++;
        if (seen != 0 || out_count !== '0)
            $display("FAIL abort_dropped got valid_cycles=%0d count=%0d exp 0/0", seen, out_count);
        else pass_cnt++;
        job_q = '{2};
        drive_job(1'b0, 1'b1, ok);
        wait_result(lat, s, o, c);
        chk_cnt++;
        if (lat != 2 || s !== 12'd2 || c !== 8'd1 || o !== 1'b0)
            $display("FAIL abort_next_job got lat=%0d sum=%0d cnt=%0d ovf=%b exp 2/2/1/0", lat, s, c, o);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_midjob();
        bit ok; int lat; logic [ACC-1:0] s; logic o; logic [CNT-1:0] c; int seen;
        job_q = '{int'($urandom_range(1, 15)), int'($urandom_range(1, 15))};
        drive_job(1'b0, 1'b0, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (out_count !== '0 || in_ready !== 1'b0)
            $display("FAIL rst_mid_clear got count=%0d ready=%b exp 0/0", out_count, in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk_cnt++;
        if (seen != 0) $display("FAIL rst_mid_no_result got %0d valid cycles exp 0", seen); else pass_cnt++;
        job_q = '{1};
        drive_job(1'b0, 1'b1, ok);
        wait_result(lat, s, o, c);
        chk_cnt++;
        if (lat != 2 || s !== 12'd1 || c !== 8'd1 || o !== 1'b0)
            $display("FAIL rst_mid_next_job got lat=%0d sum=%0d cnt=%0d ovf=%b exp 2/1/1/0", lat, s, c, o);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ok; int lat; logic [ACC-1:0] s; logic o; logic [CNT-1:0] c;
        int es; bit eo; int ec; int n;
        for (int j = 0; j < 20; j++) begin
            job_q = '{};
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) job_q.push_back(int'($urandom_range(0, 15)));
            model_job(es, eo, ec);
            drive_job(1'b1, 1'b1, ok);
            wait_result(lat, s, o, c);
            chk_cnt++;
            if (ok !== 1'b1 || lat != 2 || s !== ACC'(es) || o !== eo || c !== CNT'(ec))
                $display("FAIL random_job%0d got lat=%0d sum=%0d ovf=%b cnt=%0d exp 2/%0d/%b/%0d",
                         j, lat, s, o, c, es, eo, ec);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // Long job: count saturates while the sum keeps accumulating past the range
    task automatic test_saturate();
        bit ok; int lat; logic [ACC-1:0] s; logic o; logic [CNT-1:0] c;
        int es; bit eo; int ec;
        job_q = '{};
        for (int i = 0; i < 300; i++) job_q.push_back(int'($urandom_range(14, 15)));
        model_job(es, eo, ec);
        drive_job(1'b0, 1'b1, ok);
        wait_result(lat, s, o, c);
        chk_cnt++;
        if (c !== CNT'(ec)) $display("FAIL sat_count got %0d exp %0d", c, ec); else pass_cnt++;
        chk_cnt++;
        if (s !== ACC'(es) || o !== eo) $display("FAIL sat_sum_ovf got %0d/%b exp %0d/%b", s, o, es, eo); else pass_cnt++;
        @(negedge clk);
    endtask

    // Narrow accumulator: five 15s total 75, which wraps a 6-bit result to 11
    task automatic test_overflow_narrow();
        int lat;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_in_valid = 1'b1;
            n_in_data  = 4'd15;
            n_in_last  = (i == 4);
        end
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        n_in_last  = 1'b0;
        lat = 0;
        @(negedge clk);
        while (n_out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk_cnt++;
        if (lat != 2) $display("FAIL narrow_latency got %0d exp 2", lat); else pass_cnt++;
        chk_cnt++;
        if (n_out_sum !== 6'd11) $display("FAIL narrow_sum got %0d exp 11", n_out_sum); else pass_cnt++;
        chk_cnt++;
        if (n_out_ovf !== 1'b1 || n_out_count !== 8'd5)
            $display("FAIL narrow_ovf_count got %b/%0d exp 1/5", n_out_ovf, n_out_count);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_abort();
        test_reset_midjob();
        test_random();
        test_saturate();
        test_overflow_narrow();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
